// File: rtl/rf_wb_queue.sv
// -----------------------------------------------------------------------------
// rf_wb_queue
//
// Write-back staging queue in front of the register file. Execute-stage results
// ({addr, data}) arrive over a valid/ready handshake and are buffered in a small
// circular FIFO. One entry per cycle drains into the register file through the
// shared write bus (rfIn) and a one-hot write-enable vector (regWrite). Entries
// that are queued but not yet committed are forwarded to the two operand read
// ports.
//
// Ports
//   clk        rising-edge clock shared with the register file
//   rst_n      asynchronous active-low reset
//   wbValid    upstream presents a result on wbAddr/wbData
//   wbReady    queue can accept this cycle (depends on registered state only)
//   wbAddr     destination register index
//   wbData     result value
//   flush      synchronous discard of every queued entry and of any push
//   rfStall    inhibit draining this cycle
//   regWrite   one-hot write enable, one bit per register
//   rfIn       write data bus to every register input
//   rdAddrA/B  operand read addresses
//   fwdHitA/B  a queued entry targets the read address
//   fwdDataA/B youngest queued value for that address (valid when hit)
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module rf_wb_queue #(
    parameter int BUS_WIDTH  = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wbValid,
    output logic                  wbReady,
    input  logic [ADDR_WIDTH-1:0] wbAddr,
    input  logic [BUS_WIDTH-1:0]  wbData,
    input  logic                  flush,
    input  logic                  rfStall,
    output logic [NUM_REGS-1:0]   regWrite,
    output logic [BUS_WIDTH-1:0]  rfIn,
    input  logic [ADDR_WIDTH-1:0] rdAddrA,
    input  logic [ADDR_WIDTH-1:0] rdAddrB,
    output logic                  fwdHitA,
    output logic [BUS_WIDTH-1:0]  fwdDataA,
    output logic                  fwdHitB,
    output logic [BUS_WIDTH-1:0]  fwdDataB,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    // Pointer and occupancy state
    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [DEPTH-1:0]      vld_reg;
    logic [DEPTH-1:0]      vld_next;

    // Entry storage; contents are don't-care until the matching valid bit is set
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [BUS_WIDTH-1:0]  data_mem [DEPTH];

    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [PTR_W-1:0]      scan_idx;

    // Ready looks only at registered occupancy: a full queue refuses a push
    // even when the head drains in the same cycle.
    assign wbReady   = (count_reg != DEPTH_C);
    assign push      = wbValid && wbReady && !flush;
    assign pop       = (count_reg != '0) && !rfStall && !flush;
    assign count     = count_reg;

    assign head_addr = addr_mem[head_reg];
    assign rfIn      = data_mem[head_reg];

    // One-hot write decode. An address at or beyond NUM_REGS matches no bit,
    // so such an entry is still popped but its write is silently dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
            assign regWrite[gi] = pop && (head_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Valid bits track occupied slots so forwarding can skip stale storage.
    always_comb begin
        vld_next = vld_reg;
        if (pop)  vld_next[head_reg] = 1'b0;
        if (push) vld_next[tail_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            vld_reg   <= '0;
        end else if (flush) begin
            // Collapse the queue onto the current tail; any push is ignored.
            head_reg  <= tail_reg;
            count_reg <= '0;
            vld_reg   <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)  head_reg <= head_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            vld_reg <= vld_next;
        end
    end

    // Storage write port; no reset needed since valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= wbAddr;
            data_mem[tail_reg] <= wbData;
        end
    end

    // Forwarding scan from oldest (head) to youngest; a later match overrides
    // an earlier one so the entry closest to tail wins. The head entry being
    // written this cycle still counts as queued.
    always_comb begin
        fwdHitA  = 1'b0;
        fwdDataA = '0;
        fwdHitB  = 1'b0;
        fwdDataB = '0;
        scan_idx = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PTR_W'(k);
            if (vld_reg[scan_idx] && (addr_mem[scan_idx] == rdAddrA)) begin
                fwdHitA  = 1'b1;
                fwdDataA = data_mem[scan_idx];
            end
            if (vld_reg[scan_idx] && (addr_mem[scan_idx] == rdAddrB)) begin
                fwdHitB  = 1'b1;
                fwdDataB = data_mem[scan_idx];
            end
        end
        // Entries being discarded this cycle are no longer visible.
        if (flush) begin
            fwdHitA = 1'b0;
            fwdHitB = 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
module tb_rf_wb_queue;

    localparam int BW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wbValid = 1'b0;
    logic          wbReady;
    logic [AW-1:0] wbAddr = '0;
    logic [BW-1:0] wbData = '0;
    logic          flush = 1'b0;
    logic          rfStall = 1'b0;
    logic [NR-1:0] regWrite;
    logic [BW-1:0] rfIn;
    logic [AW-1:0] rdAddrA = '0;
    logic [AW-1:0] rdAddrB = '0;
    logic          fwdHitA;
    logic [BW-1:0] fwdDataA;
    logic          fwdHitB;
    logic [BW-1:0] fwdDataB;
    logic [AW:0]   count;

    rf_wb_queue #(
        .BUS_WIDTH (BW),
        .NUM_REGS  (NR),
        .ADDR_WIDTH(AW),
        .DEPTH     (DP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wbValid  (wbValid),
        .wbReady  (wbReady),
        .wbAddr   (wbAddr),
        .wbData   (wbData),
        .flush    (flush),
        .rfStall  (rfStall),
        .regWrite (regWrite),
        .rfIn     (rfIn),
        .rdAddrA  (rdAddrA),
        .rdAddrB  (rdAddrB),
        .fwdHitA  (fwdHitA),
        .fwdDataA (fwdDataA),
        .fwdHitB  (fwdHitB),
        .fwdDataB (fwdDataB),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } entry_t;

    entry_t mq[$];   // reference model: everything currently queued, oldest first
    entry_t sb[$];   // scoreboard: register writes still expected, in order

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse the DUT presents must match the oldest
    // expected write.
    always @(negedge clk) begin : monitor
        entry_t        e;
        logic [NR-1:0] oh;
        if (rst_n && (regWrite != '0)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: regWrite=%b rfIn=0x%h expected none", regWrite, rfIn);
            end else begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.addr] = 1'b1;
                chk("regWrite", 32'(regWrite), 32'(oh));
                chk("rfIn", 32'(rfIn), 32'(e.data));
                $display("write r%0d <= 0x%h (regWrite=%b)", e.addr, rfIn, regWrite);
            end
        end
    end

    // Compare the DUT's combinational view of this cycle with the model, then
    // advance the model across the coming clock edge.
    task automatic model_step();
        int            n;
        logic          ha, hb, pop_e, push_e, we_e;
        logic [BW-1:0] da, db;
        entry_t        e;
        n  = mq.size();
        ha = 1'b0; hb = 1'b0; da = '0; db = '0;
        chk("wbReady", 32'(wbReady), 32'(n != DP));
        chk("count", 32'(count), 32'(n));
        if (!flush) begin
            for (int i = 0; i < n; i++) begin
                if (mq[i].addr == rdAddrA) begin ha = 1'b1; da = mq[i].data; end
                if (mq[i].addr == rdAddrB) begin hb = 1'b1; db = mq[i].data; end
            end
        end
        chk("fwdHitA", 32'(fwdHitA), 32'(ha));
        if (ha) chk("fwdDataA", 32'(fwdDataA), 32'(da));
        chk("fwdHitB", 32'(fwdHitB), 32'(hb));
        if (hb) chk("fwdDataB", 32'(fwdDataB), 32'(db));
        pop_e  = (n != 0) && !rfStall && !flush;
        we_e   = pop_e && (int'(mq[0].addr) < NR);
        chk("writeActive", 32'(regWrite != '0), 32'(we_e));
        push_e = wbValid && (n != DP) && !flush;
        if (flush) begin
            mq.delete();
            sb.delete();
        end else begin
            if (pop_e) void'(mq.pop_front());
            if (push_e) begin
                e.addr = wbAddr;
                e.data = wbData;
                mq.push_back(e);
                if (int'(wbAddr) < NR) sb.push_back(e);
            end
        end
    endtask

    task automatic step(input logic v, input logic [AW-1:0] a, input logic [BW-1:0] d,
                        input logic st, input logic fl,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        output logic acc);
        @(posedge clk);
        #1;
        wbValid = v; wbAddr = a; wbData = d;
        rfStall = st; flush = fl;
        rdAddrA = ra; rdAddrB = rb;
        #1;
        acc = v && (mq.size() != DP) && !fl;
        model_step();
    endtask

    initial begin
        logic acc;

        // Reset state
        #12;
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_wbReady", 32'(wbReady), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_fwdHitA", 32'(fwdHitA), 32'd0);
        chk("rst_fwdHitB", 32'(fwdHitB), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, written on the following cycle
        step(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 3'd3, 3'd0, acc);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd3, 3'd0, acc);
        chk("dir_single_we", 32'(regWrite), 32'h08);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd3, 3'd0, acc);

        // Fill while stalled, fifth is refused, then push+pop while full
        for (int i = 0; i < 5; i++)
            step(1'b1, AW'(i), 16'h00A0 + BW'(i), 1'b1, 1'b0, 3'd1, 3'd4, acc);
        chk("dir_full_count", 32'(count), 32'd4);
        step(1'b1, 3'd4, 16'h00A4, 1'b0, 1'b0, 3'd1, 3'd4, acc);
        chk("dir_full_refused", 32'(acc), 32'd0);
        step(1'b1, 3'd4, 16'h00A4, 1'b0, 1'b0, 3'd1, 3'd4, acc);
        chk("dir_next_accept", 32'(acc), 32'd1);
        repeat (6) step(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0, acc);

        // Forwarding picks the youngest entry for a repeated address
        step(1'b1, 3'd2, 16'h0011, 1'b1, 1'b0, 3'd2, 3'd5, acc);
        step(1'b1, 3'd2, 16'h0022, 1'b1, 1'b0, 3'd2, 3'd5, acc);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd2, 3'd5, acc);
        chk("dir_fwdDataA", 32'(fwdDataA), 32'h0022);
        repeat (4) step(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd2, 3'd5, acc);

        // Flush with a concurrent push discards everything
        for (int i = 0; i < 3; i++)
            step(1'b1, AW'(i + 4), 16'h0F00 + BW'(i), 1'b1, 1'b0, 3'd6, 3'd0, acc);
        step(1'b1, 3'd7, 16'hBEEF, 1'b0, 1'b1, 3'd7, 3'd4, acc);
        repeat (3) step(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd7, 3'd4, acc);

        // Asynchronous reset between edges with entries queued
        step(1'b1, 3'd1, 16'h5151, 1'b1, 1'b0, 3'd1, 3'd6, acc);
        step(1'b1, 3'd6, 16'h6666, 1'b1, 1'b0, 3'd1, 3'd6, acc);
        @(posedge clk);
        #1;
        wbValid = 1'b0;
        rfStall = 1'b0;
        #1;
        chk("pre_rst_we", 32'(regWrite), 32'h02);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_regWrite", 32'(regWrite), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_wbReady", 32'(wbReady), 32'd1);
        chk("async_rst_fwdHitA", 32'(fwdHitA), 32'd0);
        mq.delete();
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Randomized traffic
        repeat (1500)
            step(($urandom % 100) < 60, AW'($urandom), BW'($urandom),
                 ($urandom % 100) < 30, ($urandom % 100) < 3,
                 AW'($urandom), AW'($urandom), acc);
        repeat (8) step(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0, acc);
        @(negedge clk);
        chk("drained_sb", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
